// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end controller.
package spi_pkg;

  localparam int unsigned CMD_W           = 2;
  localparam int unsigned DATA_W_DEFAULT  = 8;
  localparam int unsigned FRAME_W_DEFAULT = DATA_W_DEFAULT + CMD_W;

  localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    DONE
  } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load / serial-shift register (MSB out first) with a shift counter.
// Priority: clr > load > shift. Load and clr both restart the counter.
module spi_shift_reg #(
  parameter int unsigned W = 8,
  localparam int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [W-1:0]     din,
  input  logic             shift,
  input  logic             sin,
  output logic [W-1:0]     q,
  output logic [W-1:0]     nxt_c,
  output logic [CNT_W-1:0] cnt
);

  assign nxt_c = {q[W-2:0], sin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else if (clr) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= din;
      cnt <= '0;
    end else if (shift) begin
      q   <= nxt_c;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises MOSI frames for the RAM and serialises
// read data back on MISO, tracking whether a read address has been loaded.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  localparam int unsigned FRAME_W = DATA_W + CMD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int unsigned RX_CNT_W = $clog2(FRAME_W + 1);
  localparam int unsigned TX_CNT_W = $clog2(DATA_W + 1);

  state_t state, state_d;
  logic   rd_addr_done, rd_addr_done_d;
  logic   tx_busy, tx_busy_d;
  logic   rx_valid_d;
  logic [FRAME_W-1:0] rx_data_d;

  logic rx_clr_c, rx_shift_c;
  logic tx_clr_c, tx_load_c, tx_shift_c;
  logic frame_last_c, frame_done_c, tx_last_c;

  logic [FRAME_W-1:0]  rx_q, rx_nxt_c;
  logic [RX_CNT_W-1:0] rx_cnt;
  logic [DATA_W-1:0]   tx_q, tx_nxt_c;
  logic [TX_CNT_W-1:0] tx_cnt;
  logic                unused_c;

  spi_shift_reg #(.W(FRAME_W)) u_rx_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rx_clr_c),
    .load  (1'b0),
    .din   ('0),
    .shift (rx_shift_c),
    .sin   (MOSI),
    .q     (rx_q),
    .nxt_c (rx_nxt_c),
    .cnt   (rx_cnt)
  );

  spi_shift_reg #(.W(DATA_W)) u_tx_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tx_clr_c),
    .load  (tx_load_c),
    .din   (tx_data),
    .shift (tx_shift_c),
    .sin   (1'b0),
    .q     (tx_q),
    .nxt_c (tx_nxt_c),
    .cnt   (tx_cnt)
  );

  // MISO is the serialiser MSB flop; that register is zero whenever not transmitting.
  assign MISO     = tx_q[DATA_W-1];
  assign unused_c = ^{rx_q[FRAME_W-1], tx_q[DATA_W-2:0], tx_nxt_c};

  assign frame_last_c = (rx_cnt == RX_CNT_W'(FRAME_W - 1));
  assign frame_done_c = (rx_cnt == RX_CNT_W'(FRAME_W));
  assign tx_last_c    = (tx_cnt == TX_CNT_W'(DATA_W - 1));

  // Next-state and datapath control.
  always_comb begin
    state_d        = state;
    rd_addr_done_d = rd_addr_done;
    tx_busy_d      = tx_busy;
    rx_valid_d     = 1'b0;
    rx_data_d      = rx_data;
    rx_clr_c       = 1'b0;
    rx_shift_c     = 1'b0;
    tx_clr_c       = 1'b0;
    tx_load_c      = 1'b0;
    tx_shift_c     = 1'b0;

    if (state != IDLE && SS_n) begin
      state_d    = IDLE;
      rx_clr_c   = 1'b1;
      tx_clr_c   = 1'b1;
      tx_busy_d  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rx_clr_c = 1'b1;
          if (!SS_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          if (!MOSI)             state_d = WRITE;
          else if (rd_addr_done) state_d = READ_DATA;
          else                   state_d = READ_ADD;
        end
        WRITE, READ_ADD: begin
          rx_shift_c = 1'b1;
          if (frame_last_c) begin
            rx_data_d  = rx_nxt_c;
            rx_valid_d = 1'b1;
            state_d    = DONE;
            if (state == READ_ADD) rd_addr_done_d = 1'b1;
          end
        end
        READ_DATA: begin
          if (tx_busy) begin
            if (tx_last_c) begin
              tx_clr_c       = 1'b1;
              tx_busy_d      = 1'b0;
              rd_addr_done_d = 1'b0;
              state_d        = DONE;
            end else begin
              tx_shift_c = 1'b1;
            end
          end else if (frame_done_c) begin
            if (tx_valid) begin
              tx_load_c = 1'b1;
              tx_busy_d = 1'b1;
            end
          end else begin
            rx_shift_c = 1'b1;
            if (frame_last_c) begin
              rx_data_d  = rx_nxt_c;
              rx_valid_d = 1'b1;
            end
          end
        end
        DONE: begin
          rx_clr_c = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_addr_done <= 1'b0;
      tx_busy      <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
    end else begin
      state        <= state_d;
      rd_addr_done <= rd_addr_done_d;
      tx_busy      <= tx_busy_d;
      rx_valid     <= rx_valid_d;
      rx_data      <= rx_data_d;
    end
  end

endmodule
